// File: rtl/sha3_pkg.sv
// Shared SHA3 types and constants: lane/row types, rate sizes, pad bytes,
// the packer state encoding and a byte-keep mask helper.
package sha3_pkg;

    typedef logic [63:0] lane_t;
    typedef lane_t row_t [5];

    localparam int SHA3_256_RATE_LANES = 17;
    localparam int SHA3_512_RATE_LANES = 9;
    localparam int STATE_LANES         = 25;

    localparam logic [7:0] SHA3_DOMAIN_PAD = 8'h06;
    localparam logic [7:0] KECCAK_PAD_END  = 8'h80;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_EMIT = 2'd1,
        ST_DROP = 2'd2
    } pack_state_e;

    // Mask that keeps bytes 0..nbytes-1 of a lane; nbytes >= 8 keeps all.
    function automatic lane_t keep_mask(input logic [3:0] nbytes);
        lane_t m;
        m = '0;
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < nbytes) m[b*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

endpackage

// File: rtl/i_sha3_1600_row_bus.sv
// 1600-bit state bus into the permutation pipeline: one sample strobe and
// five rows (y = 0..4) of five lanes (x = 0..4). No backpressure.
interface i_sha3_1600_row_bus;

    logic           sample;
    sha3_pkg::row_t rowa;
    sha3_pkg::row_t rowb;
    sha3_pkg::row_t rowc;
    sha3_pkg::row_t rowd;
    sha3_pkg::row_t rowe;

    modport controller (output sample, rowa, rowb, rowc, rowd, rowe);
    modport peripheral (input  sample, rowa, rowb, rowc, rowd, rowe);

endinterface

// File: rtl/sha3_pad_lane.sv
// Combinational lane finisher: drops bytes at or above nbytes, XORs the
// domain byte at position nbytes (pad lane only) and 0x80 into byte 7
// (end-of-rate lane only).
module sha3_pad_lane
    import sha3_pkg::*;
(
    input  lane_t       word,
    input  logic [3:0]  nbytes,
    input  logic        is_pad_lane,
    input  logic        is_end_lane,
    input  logic [7:0]  domain_pad,
    output lane_t       lane_out
);

    // Mask, then layer the two pad bytes; they may hit the same byte.
    always_comb begin
        lane_out = word & keep_mask(nbytes);
        if (is_pad_lane && (nbytes < 4'd8)) begin
            for (int b = 0; b < 8; b++) begin
                if (4'(b) == nbytes) lane_out[b*8 +: 8] = lane_out[b*8 +: 8] ^ domain_pad;
            end
        end
        if (is_end_lane) lane_out[63:56] = lane_out[63:56] ^ KECCAK_PAD_END;
    end

endmodule

// File: rtl/sha3_block_packer.sv
// Single-block SHA3 message packer. Collects 64-bit little-endian words
// into rate lanes, applies domain + pad10*1 padding on the last word and
// presents the full 1600-bit state for one sample cycle. Messages that do
// not fit in one rate block raise a one-cycle err pulse instead.
//
// Input handshake: a word moves when in_valid & in_ready are both high on
// a rising clk edge; in_valid may rise at any time and the word must be
// held until that edge. in_ready is low only during reset and the single
// EMIT cycle.
module sha3_block_packer
    import sha3_pkg::*;
#(
    parameter int         RATE_LANES = SHA3_256_RATE_LANES,
    parameter logic [7:0] DOMAIN_PAD = SHA3_DOMAIN_PAD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        in_last,
    input  logic [3:0]  in_bytes,
    output logic        err,
    i_sha3_1600_row_bus.controller busout,
    output logic [1:0]  dbg_state
);

    localparam int             CW       = $clog2(RATE_LANES + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(RATE_LANES);
    localparam logic [CW-1:0]  CNT_END  = CW'(RATE_LANES - 1);

    pack_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    lane_t         acc_q [RATE_LANES];
    lane_t         acc_d [RATE_LANES];
    lane_t         st_q  [STATE_LANES];
    lane_t         st_d  [STATE_LANES];
    logic          err_q, err_d;
    logic          ready_q, ready_d;

    logic          xfer;
    logic [3:0]    nbytes;
    logic          nb_full;
    logic [CW-1:0] cnt_next;
    lane_t         pad_lane;
    lane_t         padded [STATE_LANES];

    assign xfer     = in_valid & in_ready;
    assign nbytes   = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    assign nb_full  = (nbytes == 4'd8);
    assign cnt_next = cnt_q + CW'(1);

    sha3_pad_lane u_pad_lane (
        .word        (in_data),
        .nbytes      (nbytes),
        .is_pad_lane (!nb_full),
        .is_end_lane (cnt_q == CNT_END),
        .domain_pad  (DOMAIN_PAD),
        .lane_out    (pad_lane)
    );

    // Padded block image assuming the current word is the last one.
    always_comb begin
        for (int i = 0; i < STATE_LANES; i++) padded[i] = '0;
        for (int i = 0; i < RATE_LANES; i++) begin
            if (CW'(i) < cnt_q) begin
                padded[i] = acc_q[i];
            end else if (CW'(i) == cnt_q) begin
                padded[i] = pad_lane;
            end else if ((CW'(i) == cnt_next) && nb_full) begin
                padded[i] = {56'd0, DOMAIN_PAD};
            end
            // Lane cnt already got its 0x80 from the pad lane module.
            if ((i == RATE_LANES - 1) && (CW'(i) != cnt_q)) begin
                padded[i] = padded[i] ^ {KECCAK_PAD_END, 56'd0};
            end
        end
    end

    // FSM next state, lane accumulation, output latch and err pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        st_d    = st_q;
        err_d   = 1'b0;
        ready_d = 1'b1;
        unique case (state_q)
            ST_FILL: begin
                if (xfer) begin
                    if (cnt_q == CNT_FULL) begin
                        // Rate already full: the message cannot fit.
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        for (int i = 0; i < RATE_LANES; i++) acc_d[i] = '0;
                        state_d = in_last ? ST_FILL : ST_DROP;
                    end else if (in_last) begin
                        cnt_d = '0;
                        for (int i = 0; i < RATE_LANES; i++) acc_d[i] = '0;
                        if (nb_full && (cnt_q == CNT_END)) begin
                            // Exactly 8*RATE bytes: no room for the pad byte.
                            err_d = 1'b1;
                        end else begin
                            st_d    = padded;
                            state_d = ST_EMIT;
                        end
                    end else begin
                        for (int i = 0; i < RATE_LANES; i++) begin
                            if (CW'(i) == cnt_q) acc_d[i] = in_data;
                        end
                        cnt_d = cnt_next;
                    end
                end
            end
            ST_EMIT: state_d = ST_FILL;
            ST_DROP: begin
                if (xfer && in_last) state_d = ST_FILL;
            end
            default: state_d = ST_FILL;
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            for (int i = 0; i < RATE_LANES; i++)  acc_q[i] <= '0;
            for (int i = 0; i < STATE_LANES; i++) st_q[i]  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            acc_q   <= acc_d;
            st_q    <= st_d;
        end
    end

    assign in_ready      = ready_q & (state_q != ST_EMIT);
    assign err           = err_q;
    assign dbg_state     = state_q;
    assign busout.sample = (state_q == ST_EMIT);

    for (genvar gx = 0; gx < 5; gx++) begin : g_rows
        assign busout.rowa[gx] = st_q[gx];
        assign busout.rowb[gx] = st_q[5 + gx];
        assign busout.rowc[gx] = st_q[10 + gx];
        assign busout.rowd[gx] = st_q[15 + gx];
        assign busout.rowe[gx] = st_q[20 + gx];
    end

endmodule

// File: tb/tb_sha3_block_packer.sv
// Bench for sha3_block_packer: directed cases plus random messages, scored
// against a byte-level padding model.
module tb_sha3_block_packer;
    import sha3_pkg::*;

    localparam int         R  = 17;
    localparam logic [7:0] DP = 8'h06;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic [3:0]  in_bytes;
    logic        err;
    logic [1:0]  dbg_state;

    i_sha3_1600_row_bus bus();

    sha3_block_packer #(.RATE_LANES(R), .DOMAIN_PAD(DP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .err       (err),
        .busout    (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_bad = 0;

    logic [1599:0] exp_q[$];
    int            exp_cyc_q[$];
    int            exp_err_q[$];
    logic [1599:0] obs_q[$];
    int            obs_cyc_q[$];
    int            obs_err_q[$];

    logic [1599:0] last_state;
    int            prev_samp_cyc = 0;
    int            last_samp_cyc = 0;
    logic          prev_sample = 1'b0;
    logic          prev_err = 1'b0;

    logic [63:0]   msg_words[$];
    int            last_xcs[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1599:0] bus_state();
        logic [1599:0] s;
        for (int i = 0; i < 25; i++) begin
            case (i / 5)
                0: s[64*i +: 64] = bus.rowa[i % 5];
                1: s[64*i +: 64] = bus.rowb[i % 5];
                2: s[64*i +: 64] = bus.rowc[i % 5];
                3: s[64*i +: 64] = bus.rowd[i % 5];
                default: s[64*i +: 64] = bus.rowe[i % 5];
            endcase
        end
        return s;
    endfunction

    // Monitor: log samples and errors away from the active edge.
    always @(negedge clk) begin
        if (bus.sample) begin
            check("sample_pulse", 64'(prev_sample), 64'(0));
            check("ready_in_emit", 64'(in_ready), 64'(0));
            last_state    = bus_state();
            prev_samp_cyc = last_samp_cyc;
            last_samp_cyc = cyc;
            obs_q.push_back(last_state);
            obs_cyc_q.push_back(cyc);
        end
        if (err) begin
            check("err_pulse", 64'(prev_err), 64'(0));
            obs_err_q.push_back(cyc);
        end
        prev_sample = bus.sample;
        prev_err    = err;
    end

    // ---------------- reference model ----------------
    // Byte-level view: copy message bytes, XOR domain byte after the message
    // and 0x80 into the last rate byte; reject if the pad byte has no room.
    task automatic model_expect(input int lastb, input int xcs[$]);
        int n = msg_words.size();
        int nb = (lastb > 8) ? 8 : lastb;
        int len = 8 * (n - 1) + nb;
        logic [7:0] blk [200];
        logic [1599:0] st;
        if (len <= 8 * R - 1) begin
            for (int k = 0; k < 200; k++) blk[k] = 8'h00;
            for (int k = 0; k < len; k++) blk[k] = msg_words[k / 8][8 * (k % 8) +: 8];
            blk[len]       = blk[len] ^ DP;
            blk[8 * R - 1] = blk[8 * R - 1] ^ 8'h80;
            for (int k = 0; k < 200; k++) st[8 * k +: 8] = blk[k];
            exp_q.push_back(st);
            exp_cyc_q.push_back(xcs[n - 1] + 1);
        end else begin
            int k = (n < R + 1) ? n : R + 1;
            exp_err_q.push_back(xcs[k - 1] + 1);
        end
    endtask

    // ---------------- driver tasks (entered #1 after a posedge) ----------------
    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_word(input logic [63:0] d, input logic last, input logic [3:0] nb,
                              output int xc);
        int budget = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        while (!in_ready && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!in_ready) check("ready_timeout", 64'(in_ready), 64'(1));
        xc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_msg(input int lastb, input int max_gap);
        int n = msg_words.size();
        int xc;
        int xcs[$];
        for (int k = 0; k < n; k++) begin
            logic [3:0] nb = (k == n - 1) ? 4'(lastb) : 4'($urandom_range(0, 15));
            drive_word(msg_words[k], (k == n - 1), nb, xc);
            xcs.push_back(xc);
            if (max_gap > 0 && k < n - 1) idle($urandom_range(0, max_gap));
        end
        model_expect(lastb, xcs);
        last_xcs = xcs;
    endtask

    task automatic score();
        check("sample_count", 64'(obs_q.size()), 64'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            logic [1599:0] o, e;
            int oc, ec;
            o  = obs_q.pop_front();
            e  = exp_q.pop_front();
            oc = obs_cyc_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("sample_cycle", 64'(oc), 64'(ec));
            for (int i = 0; i < 25; i++) check($sformatf("lane%0d", i), o[64*i +: 64], e[64*i +: 64]);
        end
        check("err_count", 64'(obs_err_q.size()), 64'(exp_err_q.size()));
        while (obs_err_q.size() > 0 && exp_err_q.size() > 0) begin
            int oc, ec;
            oc = obs_err_q.pop_front();
            ec = exp_err_q.pop_front();
            check("err_cycle", 64'(oc), 64'(ec));
        end
        obs_q.delete(); obs_cyc_q.delete(); obs_err_q.delete();
        exp_q.delete(); exp_cyc_q.delete(); exp_err_q.delete();
    endtask

    task automatic fill_words(input int n, input logic [63:0] w);
        msg_words.delete();
        for (int k = 0; k < n; k++) msg_words.push_back(w);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int xc;
        int b2b_a_last;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_bytes = '0;

        #2;
        check("rst_ready", 64'(in_ready), 64'(0));
        check("rst_sample", 64'(bus.sample), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_lane0", bus.rowa[0], 64'(0));
        check("rst_state", 64'(dbg_state), 64'(ST_FILL));
        #20;
        rst_n = 1'b1;
        #2;
        check("ready_before_edge", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        check("ready_after_edge", 64'(in_ready), 64'(1));

        // Empty message
        msg_words.delete();
        msg_words.push_back({$urandom, $urandom});
        send_msg(0, 0);
        idle(3);
        score();
        check("empty_l0", last_state[63:0], 64'h06);
        check("empty_l16", last_state[64*16 +: 64], 64'h8000_0000_0000_0000);

        // "abc"
        msg_words.delete();
        msg_words.push_back(64'h636261);
        send_msg(3, 0);
        idle(3);
        score();
        check("abc_l0", last_state[63:0], 64'h0000_0000_0663_6261);
        check("abc_l16", last_state[64*16 +: 64], 64'h8000_0000_0000_0000);

        // 135-byte message: pad and end marker share one byte
        fill_words(16, 64'hFFFF_FFFF_FFFF_FFFF);
        msg_words.push_back(64'h00AA_AAAA_AAAA_AAAA);
        send_msg(7, 0);
        idle(3);
        score();
        check("m135_l16", last_state[64*16 +: 64], 64'h86AA_AAAA_AAAA_AAAA);
        check("m135_l15", last_state[64*15 +: 64], 64'hFFFF_FFFF_FFFF_FFFF);
        check("m135_l17", last_state[64*17 +: 64], 64'h0);

        // Exact-fill overflow
        fill_words(17, 64'h1234_5678_9ABC_DEF0);
        send_msg(8, 0);
        idle(3);
        score();

        // Long overflow with drop; ready must stay high throughout
        fill_words(20, 64'h5555_AAAA_5555_AAAA);
        send_msg(3, 0);
        check("drop_ready_held", 64'(last_xcs[19] - last_xcs[0]), 64'(19));
        idle(3);
        score();

        // Recovery
        msg_words.delete();
        msg_words.push_back(64'h636261);
        send_msg(3, 0);
        idle(3);
        score();
        check("recover_l0", last_state[63:0], 64'h0000_0000_0663_6261);

        // Back-to-back 3-word messages
        msg_words.delete();
        for (int k = 0; k < 3; k++) msg_words.push_back({$urandom, $urandom});
        send_msg(5, 0);
        b2b_a_last = last_xcs[2];
        msg_words.delete();
        for (int k = 0; k < 3; k++) msg_words.push_back({$urandom, $urandom});
        send_msg(8, 0);
        check("b2b_gap", 64'(last_xcs[0] - b2b_a_last), 64'(2));
        idle(3);
        check("b2b_spacing", 64'(last_samp_cyc - prev_samp_cyc), 64'(4));
        score();

        // Reset mid-fill
        for (int k = 0; k < 5; k++) drive_word({$urandom, $urandom}, 1'b0, 4'd0, xc);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 64'(in_ready), 64'(0));
        check("midrst_sample", 64'(bus.sample), 64'(0));
        check("midrst_err", 64'(err), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("midrst_ready_hold", 64'(in_ready), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        msg_words.delete();
        msg_words.push_back({$urandom, $urandom});
        send_msg(0, 0);
        idle(3);
        score();
        check("midrst_empty_l0", last_state[63:0], 64'h06);
        check("midrst_empty_l16", last_state[64*16 +: 64], 64'h8000_0000_0000_0000);

        // Random messages, including overflow and drop lengths
        for (int m = 0; m < 40; m++) begin
            int n = $urandom_range(1, R + 3);
            msg_words.delete();
            for (int k = 0; k < n; k++) msg_words.push_back({$urandom, $urandom});
            send_msg($urandom_range(0, 15), $urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(4);
        score();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
